// File: rtl/mult_pkg.sv
// Shared constants and helpers for the radix-4 Booth multiplier pipeline.
//   EXT_BITS : extra operand bits so signed and unsigned operands share one datapath
//   STAGES   : number of register stages (partial products, sum/carry, final sum)
//   ext_w()  : extended operand width (WIDTH+2)
//   n_pp()   : number of radix-4 Booth partial products
package mult_pkg;
  localparam int EXT_BITS = 2;
  localparam int STAGES   = 3;

  function automatic int ext_w(input int w);
    return w + EXT_BITS;
  endfunction

  function automatic int n_pp(input int w);
    return (w + EXT_BITS) / 2;
  endfunction
endpackage

// File: rtl/booth4_pp_gen.sv
// Radix-4 Booth partial-product generator.
//   a, b : multiplicand / multiplier (WIDTH bits)
//   sgn  : 1 = two's-complement operands, 0 = unsigned
//   pp   : NPP partial products, WIDTH+3 bits each, MSB inverted
// Inverting the MSB turns each signed partial product p into p + 2^(PPW-1),
// an unsigned value; the parent adds one constant row that cancels all the
// 2^(PPW-1) offsets, so no sign extension is needed in the tree.
module booth4_pp_gen
  import mult_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NPP   = n_pp(WIDTH),
  localparam int PPW   = ext_w(WIDTH) + 1
) (
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      sgn,
  output logic [NPP-1:0][PPW-1:0]   pp
);
  localparam int E = ext_w(WIDTH);

  logic [E-1:0]   a_ext, b_ext;
  logic [E:0]     b_pad;
  logic [PPW-1:0] a_one, a_two;

  // Extending both operands to E bits lets one signed Booth recoding
  // cover the unsigned case too (top digits then see zeros).
  assign a_ext = {{EXT_BITS{sgn & a[WIDTH-1]}}, a};
  assign b_ext = {{EXT_BITS{sgn & b[WIDTH-1]}}, b};
  assign b_pad = {b_ext, 1'b0};
  assign a_one = {a_ext[E-1], a_ext};
  assign a_two = {a_ext, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    logic [2:0]     dig;
    logic           neg, one, two;
    logic [PPW-1:0] mag, val;

    assign dig = b_pad[2*i+2 -: 3];
    assign neg = dig[2];
    assign one = dig[1] ^ dig[0];
    assign two = (dig == 3'b011) | (dig == 3'b100);
    assign mag = two ? a_two : (one ? a_one : '0);
    assign val = neg ? -mag : mag;
    assign pp[i] = {~val[PPW-1], val[PPW-2:0]};
  end
endmodule

// File: rtl/booth4_mult_pipe.sv
// Three-stage pipelined radix-4 Booth multiplier with valid/ready handshake.
//   sys_clk, sys_rst          : clock, async active-high reset
//   in_valid/in_ready         : operand handshake; in_signed, A_NUM, B_NUM, in_tag
//   out_valid/out_ready       : result handshake; C_NUM (2*WIDTH), out_tag
// S1: Booth partial products, S2: Wallace sum/carry, S3: final sum.
// Each stage advances when empty or when the next stage advances, so
// bubbles are always filled and a stalled result stays on C_NUM.
module booth4_mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     A_NUM,
  input  logic [WIDTH-1:0]     B_NUM,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   C_NUM,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int NPP  = n_pp(WIDTH);
  localparam int PPW  = ext_w(WIDTH) + 1;
  localparam int PW   = 2 * WIDTH;
  localparam int NROW = NPP + 1;   // partial products plus correction row

  // Rows left after lv levels of 3:2 compression.
  function automatic int rows_after(input int r, input int lv);
    int n = r;
    for (int i = 0; i < lv; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int csa_levels(input int r);
    int n = r;
    int l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  // Cancels the 2^(PPW-1) offset introduced by each inverted-MSB row.
  function automatic logic [PW-1:0] corr_row();
    logic [PW-1:0] k = '0;
    for (int i = 0; i < NPP; i++)
      if (PPW - 1 + 2 * i < PW) k = k - (PW'(1) << (PPW - 1 + 2 * i));
    return k;
  endfunction

  localparam int            NLVL = csa_levels(NROW);
  localparam logic [PW-1:0] CORR = corr_row();

  logic [NPP-1:0][PPW-1:0] pp, s1_pp;
  logic [STAGES:1]         vld;
  logic [TAG_W-1:0]        s1_tag, s2_tag;
  logic [PW-1:0]           s2_sum, s2_cry;
  logic                    adv1, adv2, adv3;
  logic [PW-1:0]           tree [NLVL+1][NROW];

  booth4_pp_gen #(.WIDTH(WIDTH)) u_pp (
    .a   (A_NUM),
    .b   (B_NUM),
    .sgn (in_signed),
    .pp  (pp)
  );

  assign adv3      = ~vld[3] | out_ready;
  assign adv2      = ~vld[2] | adv3;
  assign adv1      = ~vld[1] | adv2;
  assign in_ready  = adv1 & ~sys_rst;
  assign out_valid = vld[3];

  // Wallace tree: level 0 is the aligned partial products plus correction;
  // each later level compresses groups of three rows into sum/carry and
  // passes the leftover rows through. Unused row slots are tied to zero.
  for (genvar lv = 0; lv <= NLVL; lv++) begin : g_lvl
    if (lv == 0) begin : g_in
      for (genvar r = 0; r < NPP; r++) begin : g_row
        assign tree[0][r] = {{(PW-PPW){1'b0}}, s1_pp[r]} << (2 * r);
      end
      assign tree[0][NPP] = CORR;
    end else begin : g_csa
      localparam int RP = rows_after(NROW, lv - 1);
      localparam int R  = rows_after(NROW, lv);
      for (genvar g = 0; g < RP / 3; g++) begin : g_fa
        logic [PW-1:0] x, y, z;
        assign x = tree[lv-1][3*g];
        assign y = tree[lv-1][3*g+1];
        assign z = tree[lv-1][3*g+2];
        assign tree[lv][2*g]   = x ^ y ^ z;
        assign tree[lv][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
      end
      for (genvar r = 0; r < RP % 3; r++) begin : g_pass
        assign tree[lv][2*(RP/3)+r] = tree[lv-1][3*(RP/3)+r];
      end
      for (genvar r = R; r < NROW; r++) begin : g_zero
        assign tree[lv][r] = '0;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld     <= '0;
      s1_pp   <= '0;
      s1_tag  <= '0;
      s2_sum  <= '0;
      s2_cry  <= '0;
      s2_tag  <= '0;
      C_NUM   <= '0;
      out_tag <= '0;
    end else begin
      // Data only loads with a valid operation so C_NUM keeps the last result.
      if (adv1) begin
        vld[1] <= in_valid;
        if (in_valid) begin
          s1_pp  <= pp;
          s1_tag <= in_tag;
        end
      end
      if (adv2) begin
        vld[2] <= vld[1];
        if (vld[1]) begin
          s2_sum <= tree[NLVL][0];
          s2_cry <= tree[NLVL][1];
          s2_tag <= s1_tag;
        end
      end
      if (adv3) begin
        vld[3] <= vld[2];
        if (vld[2]) begin
          C_NUM   <= s2_sum + s2_cry;
          out_tag <= s2_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth4_mult_pipe.sv
// Scoreboard bench: directed and random traffic on a WIDTH=16 instance,
// plus random-only traffic on WIDTH=8 and WIDTH=32 instances.
module tb_booth4_mult_pipe;
  typedef struct {
    logic [63:0] c;
    logic [3:0]  tag;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference product: interpret operands as w-bit signed or unsigned
  // integers, multiply, reduce modulo 2^(2w).
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn, input int w);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'({32'b0, a});
    sb = longint'({32'b0, b});
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    p = 64'(sa * sb);
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- WIDTH = 16 instance ----------------
  logic        sys_rst = 1'b1;
  logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b0;
  logic [15:0] a_num = '0, b_num = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid;
  logic [31:0] c_num;
  logic [3:0]  out_tag;
  int          rdy_ctl = 1;   // 0: hold low, 1: hold high, 2: random
  exp_t        q16[$];

  booth4_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .A_NUM     (a_num),
    .B_NUM     (b_num),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C_NUM     (c_num),
    .out_tag   (out_tag)
  );

  initial forever begin
    @(posedge sys_clk);
    #2;
    out_ready = (rdy_ctl == 2) ? 1'($urandom_range(0, 1)) : (rdy_ctl == 1);
  end

  initial begin : mon16
    exp_t        e;
    logic        hold_v = 1'b0;
    logic [31:0] hold_c = '0;
    logic [3:0]  hold_t = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && hold_v) begin
        chk("hold_valid16", 64'(out_valid), 64'd1);
        chk("hold_c16", 64'(c_num), 64'(hold_c));
        chk("hold_tag16", 64'(out_tag), 64'(hold_t));
      end
      if (!sys_rst && out_valid && out_ready) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected16: got result %0h tag %0h, expected none", c_num, out_tag);
        end else begin
          e = q16.pop_front();
          chk("prod16", 64'(c_num), e.c);
          chk("tag16", 64'(out_tag), 64'(e.tag));
        end
      end
      hold_v = !sys_rst && out_valid && !out_ready;
      hold_c = c_num;
      hold_t = out_tag;
    end
  end

  task automatic push16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [3:0] t);
    exp_t e;
    e.c   = ref_mul(32'(a), 32'(b), s, 16);
    e.tag = t;
    q16.push_back(e);
  endtask

  // Present one operation from posedge+1, return at posedge+1 after acceptance.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [3:0] t, input bit track);
    bit ok = 0;
    in_valid = 1'b1; a_num = a; b_num = b; in_signed = s; in_tag = t;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge sys_clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept16: got no in_ready within 100 cycles, expected acceptance");
    end else if (track) push16(a, b, s, t);
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain16();
    for (int k = 0; k < 200 && (q16.size() != 0 || out_valid); k++) begin
      @(negedge sys_clk);
      #1;
    end
    chk("drain16_empty", 64'(q16.size()), 64'd0);
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------- WIDTH = 8 / 32 random instances ----------------
  bit gdone [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
    localparam int GW = (gi == 0) ? 8 : 32;
    logic            rst = 1'b1, iv = 1'b0, sg = 1'b0, ordy = 1'b0, fin = 1'b0;
    logic [GW-1:0]   a = '0, b = '0;
    logic [3:0]      it = '0, ot;
    logic            ir, ov;
    logic [2*GW-1:0] c;
    exp_t            q[$];

    booth4_mult_pipe #(.WIDTH(GW), .TAG_W(4)) dut_r (
      .sys_clk   (sys_clk),
      .sys_rst   (rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_signed (sg),
      .A_NUM     (a),
      .B_NUM     (b),
      .in_tag    (it),
      .out_valid (ov),
      .out_ready (ordy),
      .C_NUM     (c),
      .out_tag   (ot)
    );

    initial forever begin
      @(posedge sys_clk);
      #2;
      ordy = fin ? 1'b1 : 1'($urandom_range(0, 1));
    end

    initial begin : mon
      exp_t e;
      forever begin
        @(negedge sys_clk);
        if (!rst && ov && ordy) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_w%0d: got result %0h, expected none", GW, c);
          end else begin
            e = q.pop_front();
            chk($sformatf("prod_w%0d", GW), 64'(c), e.c);
            chk($sformatf("tag_w%0d", GW), 64'(ot), 64'(e.tag));
          end
        end
      end
    end

    initial begin : stim
      exp_t e;
      bit   ok;
      repeat (2) @(posedge sys_clk);
      #1;
      rst = 1'b0;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge sys_clk);
          #1;
        end
        iv = 1'b1;
        a  = GW'($urandom);
        b  = GW'($urandom);
        sg = 1'($urandom_range(0, 1));
        it = 4'($urandom);
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
          @(negedge sys_clk);
          ok = ir;
        end
        if (!ok) begin
          checks++;
          errors++;
          $display("FAIL accept_w%0d: got no in_ready within 100 cycles, expected acceptance", GW);
        end else begin
          e.c   = ref_mul(32'(a), 32'(b), sg, GW);
          e.tag = it;
          q.push_back(e);
        end
        @(posedge sys_clk);
        #1;
        iv = 1'b0;
      end
      fin = 1'b1;
      for (int k = 0; k < 200 && q.size() != 0; k++) begin
        @(negedge sys_clk);
        #1;
      end
      chk($sformatf("drain_w%0d", GW), 64'(q.size()), 64'd0);
      gdone[gi] = 1'b1;
    end
  end

  // ---------------- directed + random sequence on WIDTH = 16 ----------------
  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    logic [3:0]  rt;
    int          cnt;

    // Reset state
    @(negedge sys_clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_c_num", 64'(c_num), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge sys_clk);
    #1;

    // Latency: most negative squared, result visible three cycles after transfer
    send16(16'h8000, 16'h8000, 1'b1, 4'h5, 1);
    @(negedge sys_clk); chk("lat_cycle1", 64'(out_valid), 64'd0);
    @(negedge sys_clk); chk("lat_cycle2", 64'(out_valid), 64'd0);
    @(negedge sys_clk); chk("lat_cycle3", 64'(out_valid), 64'd1);
    drain16();

    // All-ones operands, unsigned then signed
    send16(16'hFFFF, 16'hFFFF, 1'b0, 4'h1, 1);
    send16(16'hFFFF, 16'hFFFF, 1'b1, 4'h2, 1);
    drain16();

    // Back-to-back mixed stream: results on consecutive cycles
    send16(16'hFFFF, 16'h0001, 1'b1, 4'h1, 1);
    send16(16'h0003, 16'h0005, 1'b0, 4'h2, 1);
    send16(16'hFFF9, 16'h0006, 1'b1, 4'h3, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_tag", 64'(out_tag), 64'(k + 1));
    end
    drain16();

    // Stall: out_ready low for 5 cycles with continuous in_valid
    rdy_ctl = 0;
    ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rt = 4'($urandom);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a_num = ra; b_num = rb; in_signed = rs; in_tag = rt;
      @(negedge sys_clk);
      chk("stall_in_ready", 64'(in_ready), (i < 3) ? 64'd1 : 64'd0);
      if (in_ready) begin
        push16(ra, rb, rs, rt);
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rt = 4'($urandom);
      end
      @(posedge sys_clk);
      #1;
    end
    rdy_ctl = 1;
    send16(ra, rb, rs, rt, 1);
    send16(16'($urandom), 16'($urandom), 1'b1, 4'hA, 1);
    drain16();

    // Reset with two operations in flight
    send16(16'h1234, 16'h5678, 1'b0, 4'h7, 0);
    send16(16'h4321, 16'h8765, 1'b1, 4'h8, 0);
    @(posedge sys_clk);
    #1;
    chk("rst_inflight_valid", 64'(out_valid), 64'd1);
    sys_rst = 1'b1;
    #1;
    chk("rst_imm_valid", 64'(out_valid), 64'd0);
    chk("rst_imm_c", 64'(c_num), 64'd0);
    chk("rst_imm_tag", 64'(out_tag), 64'd0);
    chk("rst_imm_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      if (k == 0) chk("rst_release_in_ready", 64'(in_ready), 64'd1);
      if (out_valid) cnt++;
    end
    chk("rst_no_output", 64'(cnt), 64'd0);
    @(posedge sys_clk);
    #1;

    // Random stream with random out_ready and idle gaps
    rdy_ctl = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge sys_clk);
        #1;
      end
      send16(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), 1);
    end
    rdy_ctl = 1;
    drain16();

    for (int k = 0; k < 20000 && !(gdone[0] && gdone[1]); k++) @(negedge sys_clk);
    if (!(gdone[0] && gdone[1])) begin
      checks++;
      errors++;
      $display("FAIL random_done: got unfinished random streams, expected completion");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth4_mult_pipe.md
BOOTH4_MULT_PIPE -- requirements
Module: booth4_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width; SHALL be even and >= 4.
REQ-002 Parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block can accept operands this cycle.
REQ-007 in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 A_NUM  input  WIDTH  multiplicand.
REQ-009 B_NUM  input  WIDTH  multiplier.
REQ-010 in_tag  input  TAG_W  sideband tag, returned unmodified with the result.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 C_NUM  output  2*WIDTH  product.
REQ-014 out_tag  output  TAG_W  tag of the operation whose product is on C_NUM.

Function
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-016 Operands SHALL be extended to WIDTH+2 bits: sign-extended if in_signed=1, zero-extended otherwise; N_PP = (WIDTH+2)/2 radix-4 Booth partial products.
REQ-017 Pipeline SHALL have 3 register stages: S1 holds Booth partial products; S2 holds Wallace-compressed sum/carry pair; S3 holds the final carry-propagate sum on C_NUM.
REQ-018 Latency SHALL be 3 cycles from input transfer to out_valid when no stall occurs.
REQ-019 Throughput SHALL be 1 operation per cycle when out_ready is held high.
REQ-020 Each stage SHALL carry a valid bit and the tag; empty stages (bubbles) SHALL be overwritten regardless of downstream stall.
REQ-021 Stage k SHALL advance when stage k is empty or stage k+1 advances; S3 advances when empty or out_ready=1.
REQ-022 in_ready SHALL equal "S1 advances" and SHALL be combinational from the stage valid bits and out_ready only, never from in_valid.
REQ-023 C_NUM and out_tag SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 C_NUM SHALL be the exact product modulo 2^(2*WIDTH): signed product if in_signed=1, unsigned otherwise; no overflow is possible.
REQ-025 Operation order SHALL be preserved; no result dropped or duplicated under any out_ready pattern.
REQ-026 in_signed SHALL be captured per operation; mixed signed/unsigned streams SHALL be supported back-to-back.

Reset
REQ-027 On sys_rst assertion, all stage valid bits SHALL clear immediately: out_valid=0, C_NUM=0, out_tag=0.
REQ-028 in_ready SHALL be 0 while sys_rst=1 and 1 in the first cycle after deassertion.
REQ-029 Operations in flight at reset SHALL be discarded, with no output after reset.
REQ-030 Datapath registers SHALL reset to 0.

Structure
REQ-031 Shared package mult_pkg SHALL hold the N_PP function, the extended-width constant (WIDTH+2) and the stage-count constant (3).
REQ-032 One sub-module booth4_pp_gen (parametrised by WIDTH; operands and signed flag in, N_PP partial products of WIDTH+3 bits with sign-extension prevention out) SHALL be instantiated.
REQ-033 The Wallace tree and final adder SHALL be generate-loop logic inside booth4_mult_pipe.

Verification
REQ-034 WIDTH=16, signed, A=0x8000, B=0x8000, out_ready=1 -> C_NUM=0x40000000 exactly 3 cycles after transfer.
REQ-035 WIDTH=16, unsigned, A=0xFFFF, B=0xFFFF -> C_NUM=0xFFFE0001; same operands signed -> 0x00000001.
REQ-036 Back-to-back stream (signed -1*1, unsigned 3*5, signed -7*6), tags 1,2,3 -> C_NUM 0xFFFFFFFF, 0x0000000F, 0xFFFFFFD6 on consecutive cycles with tags 1,2,3.
REQ-037 Hold out_ready=0 for 5 cycles with continuous in_valid -> in_ready falls after 3 accepts, C_NUM stable, then all results drain in order with none lost.
REQ-038 Assert sys_rst with 2 operations in flight -> out_valid=0 immediately; neither result appears after release.
REQ-039 Random signed/unsigned operands at WIDTH=8, 16 and 32 with random out_ready -> every product matches the reference model and tag.
